// File: rtl/q_update_sched.sv
// Q-learning update scheduler: round-robin grant, Q(s,a) read, max scan of
// Q(s',*), operand drive to the shared update datapath, and write-back.
module q_update_sched #(
   parameter int NUM_REQ     = 4,
   parameter int NUM_ACTIONS = 4,
   parameter int STATE_W     = 8,
   parameter int ACT_W       = 2,
   parameter int DATA_W      = 32,
   parameter int UPD_LAT     = 1,
   localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int AW         = STATE_W + ACT_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*STATE_W-1:0]  req_state,
   input  logic [NUM_REQ*ACT_W-1:0]    req_action,
   input  logic [NUM_REQ*STATE_W-1:0]  req_next_state,
   input  logic [NUM_REQ*DATA_W-1:0]   req_reward,
   input  logic [NUM_REQ-1:0]          req_terminal,
   output logic [NUM_REQ-1:0]          req_ack,
   output logic                        done,
   output logic [ID_W-1:0]             done_id,
   output logic                        busy,
   input  logic                        cfg_we,
   input  logic [DATA_W-1:0]           cfg_alpha,
   input  logic [DATA_W-1:0]           cfg_gamma,
   output logic                        mem_rd_en,
   output logic [AW-1:0]               mem_rd_addr,
   input  logic [DATA_W-1:0]           mem_rd_data,
   output logic                        mem_wr_en,
   output logic [AW-1:0]               mem_wr_addr,
   output logic [DATA_W-1:0]           mem_wr_data,
   output logic [DATA_W-1:0]           upd_current_q,
   output logic [DATA_W-1:0]           upd_reward,
   output logic [DATA_W-1:0]           upd_next_q_max,
   output logic [DATA_W-1:0]           upd_alpha,
   output logic [DATA_W-1:0]           upd_gamma,
   input  logic [DATA_W-1:0]           upd_q
);

   localparam int IDX_W = ID_W + 1;
   localparam int CNT_W = ACT_W + 1;
   localparam int LAT_W = (UPD_LAT > 1) ? $clog2(UPD_LAT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_LAST,
      S_EXEC,
      S_WB
   } state_e;

   state_e state_q, state_d;

   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [DATA_W-1:0]  alpha_q, alpha_d;
   logic [DATA_W-1:0]  gamma_q, gamma_d;
   logic [STATE_W-1:0] s_q, s_d;
   logic [ACT_W-1:0]   a_q, a_d;
   logic [STATE_W-1:0] sn_q, sn_d;
   logic [DATA_W-1:0]  r_q, r_d;
   logic               term_q, term_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [DATA_W-1:0]  t_alpha_q, t_alpha_d;
   logic [DATA_W-1:0]  t_gamma_q, t_gamma_d;
   logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
   logic               cap_vld_q, cap_vld_d;
   logic [CNT_W-1:0]   cap_idx_q, cap_idx_d;
   logic [DATA_W-1:0]  cur_q_q, cur_q_d;
   logic [DATA_W-1:0]  max_q, max_d;
   logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;

   logic               gnt_found;
   logic [ID_W-1:0]    gnt_idx;
   logic [IDX_W-1:0]   scan_idx;
   logic               grant;
   logic               last_issue;
   logic               lat_done;

   // Search from ptr+1 with wrap; the first valid hit wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = {1'b0, ptr_q} + IDX_W'(k);
         if (scan_idx >= IDX_W'(NUM_REQ))
            scan_idx = scan_idx - IDX_W'(NUM_REQ);
         if (!gnt_found && req_valid[scan_idx[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan_idx[ID_W-1:0];
         end
      end
   end

   assign grant = (state_q == S_IDLE) && gnt_found && !rst;

   assign last_issue = term_q ? (rd_cnt_q == '0)
                              : (rd_cnt_q == CNT_W'(NUM_ACTIONS));

   assign lat_done = (lat_cnt_q == LAT_W'(UPD_LAT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (grant) state_d = S_RD;
         S_RD:   if (last_issue) state_d = S_LAST;
         S_LAST: state_d = S_EXEC;
         S_EXEC: if (lat_done) state_d = S_WB;
         S_WB:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ack        = '0;
      busy           = (state_q != S_IDLE);
      mem_rd_en      = 1'b0;
      mem_rd_addr    = '0;
      mem_wr_en      = 1'b0;
      mem_wr_addr    = '0;
      mem_wr_data    = '0;
      done           = 1'b0;
      done_id        = '0;
      upd_current_q  = cur_q_q;
      upd_reward     = r_q;
      upd_next_q_max = max_q;
      upd_alpha      = t_alpha_q;
      upd_gamma      = t_gamma_q;
      unique case (state_q)
         S_IDLE: if (grant) req_ack = NUM_REQ'(1) << gnt_idx;
         S_RD: begin
            mem_rd_en = 1'b1;
            if (rd_cnt_q == '0)
               mem_rd_addr = {s_q, a_q};
            else
               mem_rd_addr = {sn_q, ACT_W'(rd_cnt_q - CNT_W'(1))};
         end
         S_WB: begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = {s_q, a_q};
            mem_wr_data = upd_q;
            done        = 1'b1;
            done_id     = id_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      ptr_d     = ptr_q;
      alpha_d   = alpha_q;
      gamma_d   = gamma_q;
      s_d       = s_q;
      a_d       = a_q;
      sn_d      = sn_q;
      r_d       = r_q;
      term_d    = term_q;
      id_d      = id_q;
      t_alpha_d = t_alpha_q;
      t_gamma_d = t_gamma_q;
      rd_cnt_d  = rd_cnt_q;
      cur_q_d   = cur_q_q;
      max_d     = max_q;
      lat_cnt_d = lat_cnt_q;
      cap_vld_d = (state_q == S_RD);
      cap_idx_d = rd_cnt_q;

      if (cfg_we) begin
         alpha_d = cfg_alpha;
         gamma_d = cfg_gamma;
      end

      if (grant) begin
         ptr_d     = gnt_idx;
         id_d      = gnt_idx;
         t_alpha_d = alpha_q;
         t_gamma_d = gamma_q;
         rd_cnt_d  = '0;
         cur_q_d   = '0;
         max_d     = '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == gnt_idx) begin
               s_d    = req_state[i*STATE_W +: STATE_W];
               a_d    = req_action[i*ACT_W +: ACT_W];
               sn_d   = req_next_state[i*STATE_W +: STATE_W];
               r_d    = req_reward[i*DATA_W +: DATA_W];
               term_d = req_terminal[i];
            end
         end
      end

      if (state_q == S_RD)
         rd_cnt_d = rd_cnt_q + CNT_W'(1);

      // Read data lags issue by one cycle; index 0 is Q(s,a).
      if (cap_vld_q) begin
         if (cap_idx_q == '0)
            cur_q_d = mem_rd_data;
         else if (cap_idx_q == CNT_W'(1))
            max_d = mem_rd_data;
         else if ($signed(mem_rd_data) > $signed(max_q))
            max_d = mem_rd_data;
      end

      if (state_q == S_LAST)
         lat_cnt_d = '0;
      else if (state_q == S_EXEC)
         lat_cnt_d = lat_cnt_q + LAT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q     <= ID_W'(NUM_REQ - 1);
         alpha_q   <= '0;
         gamma_q   <= '0;
         s_q       <= '0;
         a_q       <= '0;
         sn_q      <= '0;
         r_q       <= '0;
         term_q    <= 1'b0;
         id_q      <= '0;
         t_alpha_q <= '0;
         t_gamma_q <= '0;
         rd_cnt_q  <= '0;
         cap_vld_q <= 1'b0;
         cap_idx_q <= '0;
         cur_q_q   <= '0;
         max_q     <= '0;
         lat_cnt_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         alpha_q   <= alpha_d;
         gamma_q   <= gamma_d;
         s_q       <= s_d;
         a_q       <= a_d;
         sn_q      <= sn_d;
         r_q       <= r_d;
         term_q    <= term_d;
         id_q      <= id_d;
         t_alpha_q <= t_alpha_d;
         t_gamma_q <= t_gamma_d;
         rd_cnt_q  <= rd_cnt_d;
         cap_vld_q <= cap_vld_d;
         cap_idx_q <= cap_idx_d;
         cur_q_q   <= cur_q_d;
         max_q     <= max_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

endmodule

// File: tb/tb_q_update_sched.sv
// Scoreboard bench for q_update_sched: stimulus pushes expected acks, reads
// and write-backs; a negedge monitor pops and compares them.
module tb_q_update_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid;
   logic [31:0] req_state;
   logic [7:0]  req_action;
   logic [31:0] req_next_state;
   logic [127:0] req_reward;
   logic [3:0]  req_terminal;
   logic [3:0]  req_ack;
   logic        done;
   logic [1:0]  done_id;
   logic        busy;
   logic        cfg_we;
   logic [31:0] cfg_alpha;
   logic [31:0] cfg_gamma;
   logic        mem_rd_en;
   logic [9:0]  mem_rd_addr;
   logic [31:0] mem_rd_data;
   logic        mem_wr_en;
   logic [9:0]  mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] upd_current_q, upd_reward, upd_next_q_max;
   logic [31:0] upd_alpha, upd_gamma, upd_q;

   logic [7:0]  st [4];
   logic [7:0]  sn [4];
   logic [1:0]  ac [4];
   logic [31:0] rw [4];

   assign req_state      = {st[3], st[2], st[1], st[0]};
   assign req_next_state = {sn[3], sn[2], sn[1], sn[0]};
   assign req_action     = {ac[3], ac[2], ac[1], ac[0]};
   assign req_reward     = {rw[3], rw[2], rw[1], rw[0]};

   q_update_sched dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_state(req_state),
      .req_action(req_action), .req_next_state(req_next_state),
      .req_reward(req_reward), .req_terminal(req_terminal),
      .req_ack(req_ack), .done(done), .done_id(done_id), .busy(busy),
      .cfg_we(cfg_we), .cfg_alpha(cfg_alpha), .cfg_gamma(cfg_gamma),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data),
      .upd_current_q(upd_current_q), .upd_reward(upd_reward),
      .upd_next_q_max(upd_next_q_max), .upd_alpha(upd_alpha),
      .upd_gamma(upd_gamma), .upd_q(upd_q)
   );

   always #5 clk = ~clk;

   // Q-table RAM with a preload port, plus a 1-cycle update stub.
   logic [31:0] mem [1024];
   logic        pl_en;
   logic [9:0]  pl_addr;
   logic [31:0] pl_data;
   int          cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      upd_q <= upd_current_q + upd_reward + upd_next_q_max
               + upd_alpha + upd_gamma;
   end

   typedef struct { int id; int gap; } ack_t;
   typedef struct { int addr; int off; } rd_t;
   typedef struct {
      int id; int addr; int data; int cur; int mx; int al; int ga; int lat;
   } wb_t;

   ack_t ackq[$];
   rd_t  rdq[$];
   wb_t  wbq[$];

   int total = 0;
   int bad   = 0;
   int ack_cyc = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pre(input int a, input int d);
      pl_en = 1'b1;
      pl_addr = 10'(a);
      pl_data = 32'(d);
      @(posedge clk);
      #1;
      pl_en = 1'b0;
   endtask

   task automatic set_req(input int i, input int s, input int a,
                          input int n, input int r, input bit t);
      st[i] = 8'(s);
      ac[i] = 2'(a);
      sn[i] = 8'(n);
      rw[i] = 32'(r);
      req_terminal[i] = t;
      req_valid[i] = 1'b1;
   endtask

   task automatic expect_txn(input int id, input int s, input int a,
                             input int n, input int r, input bit term,
                             input int cur, input int mx, input int al,
                             input int ga, input int gap, input int nrd,
                             input bit wb);
      ackq.push_back(ack_t'{id, gap});
      rdq.push_back(rd_t'{s*4 + a, 1});
      for (int k = 0; k < 4; k++)
         if (!term && k + 2 <= nrd) rdq.push_back(rd_t'{n*4 + k, k + 2});
      if (wb)
         wbq.push_back(wb_t'{id, s*4 + a, cur + r + mx + al + ga,
                             cur, mx, al, ga, term ? 4 : 8});
   endtask

   task automatic wait_ack(input int i);
      int n;
      for (n = 0; n < 60; n++) begin
         @(negedge clk);
         if (req_ack[i]) break;
      end
      if (n == 60) chk("ack_timeout", 0, i);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      for (n = 0; n < 60; n++) begin
         @(negedge clk);
         if (!busy) break;
      end
      if (n == 60) chk("idle_timeout", 1, 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor
   initial begin
      ack_t a;
      rd_t  r;
      wb_t  w;
      forever begin
         @(negedge clk);
         if (req_ack != 4'b0) begin
            if (ackq.size() == 0) chk("ack_unexpected", longint'(req_ack), 0);
            else begin
               a = ackq.pop_front();
               chk("ack_vec", longint'(req_ack), longint'(1) << a.id);
               if (a.gap >= 0) chk("ack_gap", cyc - ack_cyc, a.gap);
            end
            ack_cyc = cyc;
         end
         if (mem_rd_en) begin
            if (rdq.size() == 0) chk("rd_unexpected", longint'(mem_rd_addr), -1);
            else begin
               r = rdq.pop_front();
               chk("rd_addr", longint'(mem_rd_addr), r.addr);
               chk("rd_off", cyc - ack_cyc, r.off);
            end
         end
         if (mem_wr_en || done) begin
            if (wbq.size() == 0) chk("wb_unexpected", longint'(mem_wr_addr), -1);
            else begin
               w = wbq.pop_front();
               chk("wb_wr_en", longint'(mem_wr_en), 1);
               chk("wb_done", longint'(done), 1);
               chk("wb_addr", longint'(mem_wr_addr), w.addr);
               chk("wb_data", longint'($signed(mem_wr_data)), w.data);
               chk("wb_done_id", longint'(done_id), w.id);
               chk("wb_lat", cyc - ack_cyc, w.lat);
               chk("cur_q", longint'($signed(upd_current_q)), w.cur);
               chk("next_q_max", longint'($signed(upd_next_q_max)), w.mx);
               chk("alpha", longint'($signed(upd_alpha)), w.al);
               chk("gamma", longint'($signed(upd_gamma)), w.ga);
            end
         end
      end
   end

   // Stimulus
   initial begin
      req_valid = '0;
      req_terminal = '0;
      cfg_we = 1'b0;
      cfg_alpha = '0;
      cfg_gamma = '0;
      pl_en = 1'b0;
      pl_addr = '0;
      pl_data = '0;
      for (int i = 0; i < 4; i++) begin
         st[i] = '0; sn[i] = '0; ac[i] = '0; rw[i] = '0;
      end

      for (int a = 0; a < 1024; a++) pre(a, 0);
      @(negedge clk);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_ack", longint'(req_ack), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_rd_en", longint'(mem_rd_en), 0);
      chk("rst_wr_en", longint'(mem_wr_en), 0);
      chk("rst_alpha", longint'(upd_alpha), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single request, max tie kept
      pre(14, 4); pre(20, 1); pre(21, 7); pre(22, -2); pre(23, 7);
      expect_txn(1, 3, 2, 5, 10, 0, 4, 7, 0, 0, -1, 5, 1);
      set_req(1, 3, 2, 5, 10, 0);
      wait_ack(1);
      req_valid[1] = 1'b0;
      wait_idle();

      // terminal: one read, max forced to 0
      pre(29, 100);
      expect_txn(2, 7, 1, 5, 3, 1, 100, 0, 0, 0, -1, 1, 1);
      set_req(2, 7, 1, 5, 3, 1);
      wait_ack(2);
      req_valid[2] = 1'b0;
      req_terminal[2] = 1'b0;
      wait_idle();

      // all-negative scan
      pre(36, -1); pre(40, -5); pre(41, -3); pre(42, -9); pre(43, -3);
      expect_txn(3, 9, 0, 10, 0, 0, -1, -3, 0, 0, -1, 5, 1);
      set_req(3, 9, 0, 10, 0, 0);
      wait_ack(3);
      req_valid[3] = 1'b0;
      wait_idle();

      // cfg write during EXEC of A only affects B
      pre(5, 50); pre(8, 2); pre(9, 4); pre(10, 6); pre(11, 8);
      expect_txn(0, 1, 1, 2, 1, 0, 50, 8, 0, 0, -1, 5, 1);
      set_req(0, 1, 1, 2, 1, 0);
      wait_ack(0);
      req_valid[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      cfg_we = 1'b1;
      cfg_alpha = 32'd2;
      cfg_gamma = 32'd3;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      wait_idle();
      expect_txn(1, 4, 3, 6, 5, 0, 0, 0, 2, 3, -1, 5, 1);
      set_req(1, 4, 3, 6, 5, 0);
      wait_ack(1);
      req_valid[1] = 1'b0;
      wait_idle();

      // reset at t+5: no write-back, no done
      expect_txn(2, 30, 0, 31, 0, 0, 0, 0, 0, 0, -1, 4, 0);
      set_req(2, 30, 0, 31, 0, 0);
      wait_ack(2);
      req_valid[2] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", longint'(busy), 0);
      chk("mid_rst_wr_en", longint'(mem_wr_en), 0);
      chk("mid_rst_done", longint'(done), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", longint'(busy), 0);
      @(posedge clk);
      #1;

      // fairness: 0,1,2,3,0 spaced 9 cycles
      pre(80, 3); pre(81, 1); pre(82, 3); pre(83, 2);
      expect_txn(0, 16, 0, 20, 0, 0, 0, 3, 0, 0, -1, 5, 1);
      expect_txn(1, 17, 1, 20, 1, 0, 0, 3, 0, 0, 9, 5, 1);
      expect_txn(2, 18, 2, 20, 2, 0, 0, 3, 0, 0, 9, 5, 1);
      expect_txn(3, 19, 3, 20, 3, 0, 0, 3, 0, 0, 9, 5, 1);
      expect_txn(0, 16, 0, 20, 0, 0, 3, 3, 0, 0, 9, 5, 1);
      for (int i = 0; i < 4; i++) set_req(i, 16 + i, i, 20, i, 0);
      for (int i = 0; i < 4; i++) wait_ack(i);
      wait_ack(0);
      req_valid = '0;
      wait_idle();

      repeat (3) @(negedge clk);
      chk("ackq_left", ackq.size(), 0);
      chk("rdq_left", rdq.size(), 0);
      chk("wbq_left", wbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/q_update_sched.md
Name: q_update_sched

Overview:
Controller that sequences one shared Q-learning update datapath and the Q-table memory among NUM_REQ agent requesters. It arbitrates requests round-robin and reads Q(s,a). It scans Q(s',*) to find max_a Q(s',a), drives the update datapath operands, and writes the updated Q value back to the table. One transaction is in flight at a time; it sits between the agent front-ends and the Q-table RAM.

Parameters:
NUM_REQ, 4, number of requesters
NUM_ACTIONS, 4, actions per state (power of 2)
STATE_W, 8, state index width
ACT_W, 2, action index width, equal to log2(NUM_ACTIONS)
DATA_W, 32, Q/reward/alpha/gamma width, two's complement
UPD_LAT, 1, cycles from operands stable to valid upd_q

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  NUM_REQ  per-requester request, held until ack
req_state  in  NUM_REQ*STATE_W  packed s, requester i at [i*STATE_W +: STATE_W]
req_action  in  NUM_REQ*ACT_W  packed a
req_next_state  in  NUM_REQ*STATE_W  packed s'
req_reward  in  NUM_REQ*DATA_W  packed r
req_terminal  in  NUM_REQ  s' is terminal, so next_q_max is 0
req_ack  out  NUM_REQ  one-hot, 1-cycle pulse on grant
done  out  1  1-cycle pulse at write-back
done_id  out  clog2(NUM_REQ)  requester index of completed transaction
busy  out  1  high when not IDLE
cfg_we  in  1  load alpha/gamma
cfg_alpha  in  DATA_W  learning rate
cfg_gamma  in  DATA_W  discount
mem_rd_en  out  1  Q-table read strobe
mem_rd_addr  out  STATE_W+ACT_W  {state,action}
mem_rd_data  in  DATA_W  valid the cycle after mem_rd_en
mem_wr_en  out  1  Q-table write strobe
mem_wr_addr  out  STATE_W+ACT_W  {state,action}
mem_wr_data  out  DATA_W  updated Q
upd_current_q, upd_reward, upd_next_q_max, upd_alpha, upd_gamma  out  DATA_W each  datapath operands
upd_q  in  DATA_W  datapath result

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- All outputs reset to 0. State resets to IDLE. The round-robin pointer resets to NUM_REQ-1, so requester 0 wins first. The alpha and gamma registers reset to 0.
- cfg_we is accepted in any state. The alpha/gamma values are snapshotted into the transaction at grant, so an update mid-transaction affects only later grants.
- Transaction contents:
  - At grant, the FSM latches s, a, s', r, terminal, the requester id, and the alpha/gamma snapshot.
  - upd_* outputs are driven from these registers and are stable from EXEC until the next grant.
- FSM states and transitions:
  - IDLE: if any req_valid is set, grant the first valid requester searching from pointer+1 with wrap-around. In the same cycle: pulse req_ack[i], update pointer to i, latch the transaction, go to RD. With no valid requester, stay in IDLE.
  - RD: issue reads on consecutive cycles, one per cycle. First {s,a}, then {s',0} .. {s',NUM_ACTIONS-1}. If terminal is set, only {s,a} is read. After the last issue, go to LAST.
  - Data capture runs with a 1-cycle lag (in RD and LAST). The first returned word is current_q. Each later word is a signed compare into a running max, initialised with the {s',0} word. On ties the earlier word is kept. If terminal is set, next_q_max is 0.
  - LAST: capture the final read data, then go to EXEC.
  - EXEC: hold operands for UPD_LAT cycles, then go to WB.
  - WB: mem_wr_en=1, addr={s,a}, data=upd_q; done=1, done_id=i; go to IDLE.
- Latency from ack cycle t (non-terminal): RD t+1..t+NUM_ACTIONS+1, LAST, EXEC (UPD_LAT cycles), WB.
  - Defaults (non-terminal): WB at t+8; next possible ack at t+9.
  - Defaults (terminal): WB at t+4.
- Hazards:
  - The write in WB always precedes the next transaction's first read, so no forwarding is needed.
  - s'==s is legal; the scan reads the pre-update value.
- mem_rd_en is high only in RD cycles; mem_wr_en is high only in WB.
- req_valid dropping without ack is ignored. A requester that stays valid is re-granted only after all other valid requesters have been served.
- Reset asserted mid-transaction: return to IDLE immediately. No write and no done pulse are issued, and the pending request is not acked again until rearbitrated.

Test Plan:
- Single request, req 1: s=3, a=2, s'=5, r=10. Table Q(3,2)=4, Q(5,*)={1,7,-2,7}. Expected response:
  - ack at t, reads at t+1..t+5 to addrs 14, 20, 21, 22, 23.
  - upd_current_q=4, upd_next_q_max=7.
  - WB at t+8 writes upd_q to addr 14; done_id=1.
- Terminal request: ack, then a single read at t+1. upd_next_q_max=0 and WB at t+4.
- Fairness: all four req_valid held high → ack order 0, 1, 2, 3, 0, spaced 9 cycles apart. Each done_id matches its ack.
- Negative max: Q(s',*)={-5,-3,-9,-3} → upd_next_q_max=-3 (signed compare, not unsigned).
- Config: cfg_we with alpha=2, gamma=3 during EXEC of transaction A → A keeps its old snapshot; transaction B shows upd_alpha=2, upd_gamma=3.
- Reset at t+5 of a transaction → mem_wr_en and done never asserted. busy=0 the cycle after reset, and the next grant goes to requester 0.
